// File: rtl/cov_center.sv
// Per-frame mean removal for four signed channels: buffer a frame of 2^N_LOG2
// samples, compute each channel's floor mean, then stream sample-minus-mean.
module cov_center #(
    parameter int IN_W   = 24,
    parameter int N_LOG2 = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] X1,
    input  logic signed [IN_W-1:0] X2,
    input  logic signed [IN_W-1:0] X3,
    input  logic signed [IN_W-1:0] X4,
    output logic                   En,
    output logic signed [25:0]     Xcen1,
    output logic signed [25:0]     Xcen2,
    output logic signed [25:0]     Xcen3,
    output logic signed [25:0]     Xcen4,
    output logic                   frame_done
);

    localparam int DEPTH = 1 << N_LOG2;
    localparam int AW    = IN_W + N_LOG2;
    localparam int OW    = 26;

    typedef enum logic [1:0] {LOAD, MEAN, STREAM} state_t;

    state_t              state, state_nx;
    logic [N_LOG2-1:0]   cnt;
    logic                tail;
    logic                take;
    logic [3:0][IN_W-1:0] xin;

    assign take = in_valid && in_ready;
    assign xin  = {X4, X3, X2, X1};

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (take && (&cnt)) state_nx = MEAN;
            MEAN:    state_nx = STREAM;
            STREAM:  if (tail) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // tail marks the cycle after the last output: En drops and frame_done fires
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            cnt        <= '0;
            tail       <= 1'b0;
            En         <= 1'b0;
            frame_done <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            state      <= state_nx;
            in_ready   <= (state_nx == LOAD);
            frame_done <= (state == STREAM) && tail;
            En         <= (state == STREAM) && !tail;
            case (state)
                LOAD: begin
                    if (take) cnt <= cnt + 1'b1;
                end
                STREAM: begin
                    if (tail) begin
                        tail <= 1'b0;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        tail <= &cnt;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < 4; g++) begin : lane
        logic signed [IN_W-1:0] mem [DEPTH];
        logic signed [AW-1:0]   acc;
        logic signed [IN_W-1:0] mean;
        logic signed [IN_W-1:0] x;
        logic signed [OW-1:0]   xc;

        assign x = xin[g];

        always_ff @(posedge clk) begin
            if (take) mem[cnt] <= x;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                acc  <= '0;
                mean <= '0;
                xc   <= '0;
            end else begin
                if (take) acc <= acc + AW'(x);
                if (state == STREAM && tail) acc <= '0;
                // arithmetic shift gives floor toward -inf
                if (state == MEAN) mean <= IN_W'(acc >>> N_LOG2);
                if (state == STREAM && !tail) xc <= OW'(mem[cnt]) - OW'(mean);
                else                          xc <= '0;
            end
        end
    end

    assign Xcen1 = lane[0].xc;
    assign Xcen2 = lane[1].xc;
    assign Xcen3 = lane[2].xc;
    assign Xcen4 = lane[3].xc;

endmodule

// File: doc/cov_center.md
COV_CENTER -- requirements
Module: cov_center

Parameters
REQ-001 SHALL provide parameter IN_W, default 24: signed sample width per channel.
REQ-002 SHALL provide parameter N_LOG2, default 7: frame length is 2^N_LOG2 = 128 samples.

Interface
REQ-003 clk  in  1  the only clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  X1..X4 carry a sample this cycle.
REQ-006 in_ready  out  1  block accepts a sample; a sample is taken when in_valid && in_ready.
REQ-007 X1, X2, X3, X4  in  IN_W each  signed raw channel samples.
REQ-008 En  out  1  Xcen1..Xcen4 are valid this cycle; drives the covariance multiplier enable.
REQ-009 Xcen1, Xcen2, Xcen3, Xcen4  out  26 each  signed centered samples, sign-extended.
REQ-010 frame_done  out  1  one-cycle pulse after the last centered sample of a frame.

Function
REQ-011 SHALL implement the states LOAD, MEAN and STREAM.
REQ-012 LOAD: in_ready=1; each accepted sample SHALL be stored in a 128-deep per-channel buffer at index cnt; it SHALL be added to a per-channel signed accumulator of width IN_W+N_LOG2; cnt SHALL increment.
REQ-013 A cycle with in_valid=0 in LOAD SHALL hold all state; gaps of any length are legal.
REQ-014 Acceptance of the 128th sample (cnt=127) SHALL move LOAD->MEAN, with cnt cleared to 0.
REQ-015 MEAN: lasts exactly one cycle; in_ready=0; mean_i SHALL be the accumulator arithmetic-shifted right by N_LOG2 (floor toward -inf) and registered; the state then moves to STREAM.
REQ-016 STREAM: in_ready=0; each cycle Xcen_i SHALL be buffer_i[cnt] - mean_i, computed at 26 bits and registered with En=1; cnt SHALL increment.
REQ-017 En SHALL be high for exactly 128 consecutive cycles per frame, with no gaps; the output order SHALL equal the input acceptance order.
REQ-018 The first En=1 cycle SHALL be 2 cycles after the clock edge that accepted the 128th sample.
REQ-019 After the 128th output cycle, En SHALL drop to 0; frame_done SHALL pulse for 1 cycle in that same cycle; accumulators SHALL clear; the state SHALL return to LOAD with in_ready=1.
REQ-020 in_valid asserted during MEAN or STREAM SHALL be ignored; no data is taken or lost because in_ready=0.
REQ-021 When En=0, Xcen1..Xcen4 SHALL be driven to 0.
REQ-022 The 26-bit result width SHALL never overflow for IN_W<=24; no saturation logic SHALL be present.

Reset
REQ-023 When rst=1 at a clock edge, the following SHALL take effect on that edge: state=LOAD, cnt=0, accumulators=0, means=0, En=0, Xcen1..4=0, frame_done=0, in_ready=0.
REQ-024 in_ready SHALL rise in the first cycle after rst deasserts.
REQ-025 Reset in any state, including mid-LOAD or mid-STREAM, SHALL abort the frame: En falls on the reset edge, no frame_done is issued, and buffer contents are don't-care.

Verification
REQ-026 Ramp: X1=0..127, X2=X3=X4=5 constant, in_valid held high -> mean1=63 (sum 8128); Xcen1 = -63..64 in order; Xcen2..4 all 0; En high for 128 cycles starting 2 cycles after the last accept; one frame_done pulse.
REQ-027 Floor rounding: X2=-1 for samples 0..126 and 0 for sample 127 -> sum -127, mean -1; Xcen2=0 for 127 samples, then 1.
REQ-028 Extremes: X3 alternates 8388607 / -8388608 -> mean -1; Xcen3 alternates 8388608 / -8388607 with no wrap.
REQ-029 Handshake: random in_valid gaps in LOAD, plus in_valid held high through STREAM -> output identical to the gap-free case; exactly 128 accepts per frame; back-to-back second frame correct.
REQ-030 Reset mid-STREAM at output 40 -> En=0 and Xcen=0 on the reset edge; no frame_done; in_ready=1 one cycle after rst falls; the next 128 samples produce a correct frame.
